cache_bus_arbiter: RTL and testbench

Shares the single RAM port between the instruction and data caches of `CPUS` cores. It sits between the per-core cache blocks and the `cpu_ram_if` RAM side, in place of a direct cache-to-RAM connection. Arbitration is round-robin across cores, with data before instruction inside a core. A granted request is held on the RAM port until RAM reports ACCESS.

---
 rtl/cache_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// Shares one RAM port between the data and instruction caches of CPUS cores.
// Round-robin across cores, data before instruction within a core; a grant is held until ACCESS.
module cache_bus_arbiter #(
  parameter int unsigned CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   iaddr,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS*32-1:0]   dload,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic [7:0]           err_count
);

  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned RW = CW + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [CW-1:0] LAST_RST = CW'(CPUS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] gnt_q, gnt_d;
  logic          gwr_q, gwr_d;
  logic [CW-1:0] last_q, last_d;
  logic [7:0]    err_q, err_d;

  logic [CPUS-1:0] data_req;
  logic [CW-1:0]   gnt_cpu;
  logic            gnt_instr;
  logic            gnt_pend;
  logic            ram_access;

  logic            win_found;
  logic [CW-1:0]   win_cpu;
  logic            win_instr;
  logic            win_wr;
  int unsigned     cand;

  assign data_req   = dREN | dWEN;
  assign gnt_cpu    = gnt_q[RW-1:1];
  assign gnt_instr  = gnt_q[0];
  assign gnt_pend   = gnt_instr ? iREN[gnt_cpu] : data_req[gnt_cpu];
  assign ram_access = (ramstate == RAM_ACCESS);
  assign err_count  = err_q;
  assign iload      = {CPUS{ramload}};
  assign dload      = {CPUS{ramload}};

  // Round-robin scan starting one past the last served core.
  always_comb begin
    win_found = 1'b0;
    win_cpu   = '0;
    win_instr = 1'b0;
    win_wr    = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      cand = 32'(last_q) + 32'd1 + k;
      if (cand >= CPUS) cand = cand - CPUS;
      if (!win_found && (data_req[CW'(cand)] || iREN[CW'(cand)])) begin
        win_found = 1'b1;
        win_cpu   = CW'(cand);
        win_instr = !data_req[CW'(cand)];
        win_wr    = dWEN[CW'(cand)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gwr_q   <= 1'b0;
      last_q  <= LAST_RST;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gwr_q   <= gwr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gwr_d   = gwr_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = {win_cpu, win_instr};
          gwr_d   = win_wr;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request aborts without touching the round-robin pointer.
        if (!gnt_pend) begin
          state_d = IDLE;
        end else if (ram_access) begin
          last_d  = gnt_cpu;
          state_d = RECOVER;
        end else if (ramstate == RAM_ERROR) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM side and stalls follow the registered grant and live requester inputs.
  always_comb begin
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == GRANT) begin
      ramREN = !gwr_q;
      ramWEN = gwr_q;
      if (gnt_instr) begin
        ramaddr = iaddr[32*gnt_cpu +: 32];
      end else begin
        ramaddr  = daddr[32*gnt_cpu +: 32];
        ramstore = dstore[32*gnt_cpu +: 32];
      end
      if (gnt_pend && ram_access) begin
        if (gnt_instr) iwait[gnt_cpu] = 1'b0;
        else           dwait[gnt_cpu] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a transaction-level arbitration model.
module tb_cache_bus_arbiter;

  localparam int CPUS = 2;
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  logic                CLK = 1'b0;
  logic                RST;
  logic [CPUS-1:0]     iREN, dREN, dWEN;
  logic [CPUS*32-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]     iwait, dwait;
  logic [CPUS*32-1:0]  iload, dload;
  logic [31:0]         ramaddr, ramstore, ramload;
  logic                ramREN, ramWEN;
  logic [1:0]          ramstate;
  logic [7:0]          err_count;

  cache_bus_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [31:0] store;
    bit          wr;
    logic [31:0] load;
    logic [7:0]  err;
  } exp_t;

  exp_t        q[$];
  bit          m_iren[CPUS], m_dren[CPUS], m_dwen[CPUS];
  logic [31:0] m_iaddr[CPUS], m_daddr[CPUS], m_dstore[CPUS];
  int          m_last;
  int          m_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply();
    for (int c = 0; c < CPUS; c++) begin
      iREN[c]            = m_iren[c];
      dREN[c]            = m_dren[c];
      dWEN[c]            = m_dwen[c];
      iaddr[c*32 +: 32]  = m_iaddr[c];
      daddr[c*32 +: 32]  = m_daddr[c];
      dstore[c*32 +: 32] = m_dstore[c];
    end
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < CPUS; c++) begin
      m_iren[c] = 1'b0;
      m_dren[c] = 1'b0;
      m_dwen[c] = 1'b0;
    end
  endtask

  task automatic rand_reqs();
    bit any;
    any = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      m_iren[c]   = 1'($urandom_range(0, 1));
      m_dren[c]   = 1'($urandom_range(0, 1));
      m_dwen[c]   = ($urandom_range(0, 2) == 0);
      m_iaddr[c]  = $urandom;
      m_daddr[c]  = $urandom;
      m_dstore[c] = $urandom;
      any = any | m_iren[c] | m_dren[c] | m_dwen[c];
    end
    if (!any) m_iren[$urandom_range(0, CPUS - 1)] = 1'b1;
  endtask

  // Reference arbitration: first requesting core after the last served one, data first.
  function automatic int pick();
    for (int k = 0; k < CPUS; k++) begin
      int c;
      c = (m_last + 1 + k) % CPUS;
      if (m_dren[c] || m_dwen[c]) return 2 * c;
      if (m_iren[c]) return 2 * c + 1;
    end
    return -1;
  endfunction

  // One full transaction from an IDLE cycle: n non-ACCESS RAM cycles, then ACCESS, then RECOVER.
  task automatic do_txn(input int n, input int kind, input logic [31:0] ld,
                        input bit rnd_after, output int win);
    exp_t       e;
    int         cpu;
    logic [1:0] st;
    logic [1:0] sts[$];
    win = pick();
    if (win < 0) begin
      chk("model_has_request", 32'd0, 32'd1);
      return;
    end
    cpu = win / 2;
    for (int i = 0; i < n; i++) begin
      case (kind)
        1:       st = ST_BUSY;
        2:       st = ST_ERROR;
        default: begin
          st = 2'($urandom_range(0, 2));
          if (st == ST_ACCESS) st = ST_ERROR;
        end
      endcase
      if (st == ST_ERROR && m_err < 255) m_err++;
      sts.push_back(st);
    end
    e.r     = win;
    e.addr  = (win % 2 == 1) ? m_iaddr[cpu] : m_daddr[cpu];
    e.wr    = (win % 2 == 0) && m_dwen[cpu];
    e.store = m_dstore[cpu];
    e.load  = ld;
    e.err   = 8'(m_err);
    q.push_back(e);
    step();
    foreach (sts[i]) begin
      ramstate = sts[i];
      ramload  = $urandom;
      step();
    end
    ramstate = ST_ACCESS;
    ramload  = ld;
    step();
    m_last   = cpu;
    ramstate = ST_FREE;
    ramload  = $urandom;
    if (rnd_after) begin
      rand_reqs();
      apply();
    end
    step();
  endtask

  // Monitor: checks RAM drive while a transaction is expected and pops on each completion.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        int   lows;
        int   lr;
        exp_t e;
        lows = 0;
        lr   = -1;
        for (int c = 0; c < CPUS; c++) begin
          if (!dwait[c]) begin lows++; lr = 2 * c; end
          if (!iwait[c]) begin lows++; lr = 2 * c + 1; end
        end
        if ((ramREN || ramWEN) && q.size() > 0) begin
          chk("ramaddr", ramaddr, q[0].addr);
          chk("ramWEN", 32'(ramWEN), 32'(q[0].wr));
          chk("ramREN", 32'(ramREN), 32'(!q[0].wr));
          if (q[0].wr) chk("ramstore", ramstore, q[0].store);
        end
        if (lows > 0) begin
          if (q.size() == 0) begin
            chk("spurious_wait_low", 32'(lows), 32'd0);
          end else begin
            e = q.pop_front();
            chk("wait_low_count", 32'(lows), 32'd1);
            chk("winner", 32'(lr), 32'(e.r));
            chk("enable_at_done", 32'(ramREN | ramWEN), 32'd1);
            if (e.r % 2 == 1) chk("iload", iload[(e.r / 2) * 32 +: 32], e.load);
            else              chk("dload", dload[(e.r / 2) * 32 +: 32], e.load);
            chk("err_count", 32'(err_count), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    int              w;
    logic [CPUS-1:0] ones;
    ones     = '1;
    RST      = 1'b1;
    ramstate = ST_FREE;
    ramload  = 32'd0;
    for (int c = 0; c < CPUS; c++) begin
      m_iren[c]   = 1'b1;
      m_dren[c]   = 1'b1;
      m_dwen[c]   = 1'b1;
      m_iaddr[c]  = 32'h1000 + 32'(c * 4);
      m_daddr[c]  = 32'h2000 + 32'(c * 4);
      m_dstore[c] = 32'hA000 + 32'(c);
    end
    apply();
    m_last = CPUS - 1;
    m_err  = 0;
    step();
    step();
    @(negedge CLK);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iwait", 32'(iwait), 32'(ones));
    chk("rst_dwait", 32'(dwait), 32'(ones));
    chk("rst_err_count", 32'(err_count), 32'd0);
    step();
    RST    = 1'b0;
    mon_en = 1'b1;

    // First grant after reset goes to core 0 data (write wins).
    do_txn(1, 1, $urandom, 1'b0, w);

    // Single instruction read from core 1.
    clear_reqs();
    m_iren[1]  = 1'b1;
    m_iaddr[1] = 32'h40;
    apply();
    do_txn(2, 1, 32'hDEADBEEF, 1'b0, w);

    // Write beats read within a core.
    clear_reqs();
    m_dwen[0]   = 1'b1;
    m_dren[0]   = 1'b1;
    m_daddr[0]  = 32'h80;
    m_dstore[0] = 32'h1234;
    apply();
    do_txn(1, 1, $urandom, 1'b0, w);

    // Fairness with held requests; core 0 drops its write once served.
    clear_reqs();
    m_dwen[0] = 1'b1;
    m_iren[0] = 1'b1;
    m_dren[1] = 1'b1;
    apply();
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, $urandom, 1'b0, w);
      if (w == 0) begin
        m_dwen[0] = 1'b0;
        apply();
      end
    end

    // Error retries, then saturation.
    clear_reqs();
    m_dren[1]  = 1'b1;
    m_daddr[1] = 32'hC0;
    apply();
    do_txn(3, 2, $urandom, 1'b0, w);
    do_txn(300, 2, $urandom, 1'b0, w);

    // Abort: requester withdraws during GRANT.
    clear_reqs();
    m_iren[1]  = 1'b1;
    m_iaddr[1] = 32'h44;
    apply();
    step();
    ramstate = ST_BUSY;
    @(negedge CLK);
    chk("abort_ramREN_granted", 32'(ramREN), 32'd1);
    chk("abort_ramaddr", ramaddr, 32'h44);
    step();
    m_iren[1] = 1'b0;
    apply();
    step();
    @(negedge CLK);
    chk("abort_ramREN_idle", 32'(ramREN), 32'd0);
    chk("abort_ramWEN_idle", 32'(ramWEN), 32'd0);
    step();

    // Reset while granted: enables drop next cycle, no completion, counters cleared.
    clear_reqs();
    m_dren[0]  = 1'b1;
    m_daddr[0] = 32'hE0;
    apply();
    step();
    ramstate = ST_BUSY;
    @(negedge CLK);
    chk("midrst_ramREN_granted", 32'(ramREN), 32'd1);
    step();
    RST = 1'b1;
    clear_reqs();
    apply();
    step();
    RST      = 1'b0;
    ramstate = ST_ACCESS;
    @(negedge CLK);
    chk("midrst_ramREN", 32'(ramREN), 32'd0);
    chk("midrst_ramWEN", 32'(ramWEN), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    m_last = CPUS - 1;
    m_err  = 0;
    step();
    ramstate = ST_FREE;

    // Random traffic.
    rand_reqs();
    apply();
    for (int i = 0; i < 150; i++) begin
      do_txn($urandom_range(0, 4), 0, $urandom, 1'b1, w);
    end

    clear_reqs();
    apply();
    step();
    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
